// File: rtl/key_scan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : key_scan_pkg
// Description : Shared constants and per-key FSM state type for the keypad
//               scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package key_scan_pkg;

  localparam int NUM_KEYS           = 8;
  localparam int CNT_W              = 10;

  localparam int TICK_DIV_DEF       = 50000;
  localparam int DEBOUNCE_MS_DEF    = 20;
  localparam int LONG_MS_DEF        = 600;
  localparam int REPEAT_MS_DEF      = 150;
  localparam int KEY_ACTIVE_LOW_DEF = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    DB_REL   = 3'd4
  } key_state_e;

endpackage
`default_nettype wire

// File: rtl/key_scan_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : key_scan_if
// Description : Key pins in, debounced levels and event pulses out.
//               master = panel/consumer side, slave = the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_scan_if;
  import key_scan_pkg::*;

  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;
  logic                any_event;

  modport master (
    output key_in,
    input  key_level, key_press, key_release, key_repeat, any_event
  );

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, key_repeat, any_event
  );

endinterface
`default_nettype wire

// File: rtl/key_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : key_fsm
// Description : One key's debounce / hold / auto-repeat state machine with
//               its tick counter and registered level and event outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module key_fsm
  import key_scan_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int LONG_MS     = LONG_MS_DEF,
  parameter int REPEAT_MS   = REPEAT_MS_DEF
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic tick,
  input  logic pressed,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] c_DEB_LAST  = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_MS - 1);

  key_state_e       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_level, w_level_nx;
  logic             r_press, w_press_nx;
  logic             r_rel, w_rel_nx;
  logic             r_rep, w_rep_nx;

  // State, counter and output registers; reset drops everything silently.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_level <= w_level_nx;
      r_press <= w_press_nx;
      r_rel   <= w_rel_nx;
      r_rep   <= w_rep_nx;
    end
  end

  // Next state: a change of the key level is checked before the tick.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_level_nx = r_level;
    w_press_nx = 1'b0;
    w_rel_nx   = 1'b0;
    w_rep_nx   = 1'b0;
    case (r_state)
      IDLE: begin
        if (pressed) begin
          w_state_nx = DB_PRESS;
          w_cnt_nx   = '0;
        end
      end
      DB_PRESS: begin
        if (!pressed) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else if (tick) begin
          if (r_cnt == c_DEB_LAST) begin
            w_state_nx = HELD;
            w_press_nx = 1'b1;
            w_level_nx = 1'b1;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      HELD: begin
        if (!pressed) begin
          w_state_nx = DB_REL;
          w_cnt_nx   = '0;
        end else if (tick) begin
          if (r_cnt == c_LONG_LAST) begin
            w_state_nx = REPEAT;
            w_rep_nx   = 1'b1;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!pressed) begin
          w_state_nx = DB_REL;
          w_cnt_nx   = '0;
        end else if (tick) begin
          if (r_cnt == c_REP_LAST) begin
            w_rep_nx = 1'b1;
            w_cnt_nx = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      DB_REL: begin
        // A bounce back to pressed restarts the long-press timer silently.
        if (pressed) begin
          w_state_nx = HELD;
          w_cnt_nx   = '0;
        end else if (tick) begin
          if (r_cnt == c_DEB_LAST) begin
            w_state_nx = IDLE;
            w_rel_nx   = 1'b1;
            w_level_nx = 1'b0;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign level         = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_rel;
  assign repeat_pulse  = r_rep;

endmodule
`default_nettype wire

// File: rtl/key_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : key_scan
// Description : 8-key panel scanner: synchronizers, shared 1 ms tick and
//               eight independent debounce/repeat FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
module key_scan
  import key_scan_pkg::*;
#(
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int DEBOUNCE_MS    = DEBOUNCE_MS_DEF,
  parameter int LONG_MS        = LONG_MS_DEF,
  parameter int REPEAT_MS      = REPEAT_MS_DEF,
  parameter int KEY_ACTIVE_LOW = KEY_ACTIVE_LOW_DEF
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  key_scan_if.slave  kif
);

  localparam int                  c_DIV_W     = $clog2(TICK_DIV);
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(TICK_DIV - 1);
  // Raw pin level of a released key; the synchronizer resets to it.
  localparam logic [NUM_KEYS-1:0] c_REL_LEVEL = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_KEYS-1:0] r_sync1, r_sync2;
  logic [NUM_KEYS-1:0] w_pressed;
  logic [c_DIV_W-1:0]  r_div;
  logic                w_tick;
  logic [NUM_KEYS-1:0] w_level, w_press, w_rel, w_rep;

  // Two-flop synchronizer on every raw key pin.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      r_sync1 <= c_REL_LEVEL;
      r_sync2 <= c_REL_LEVEL;
    end else begin
      r_sync1 <= kif.key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  // Shared tick divider, wraps at TICK_DIV-1.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (r_div == c_DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = (r_div == c_DIV_LAST);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_fsm #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_key_fsm (
      .clk_50M       (clk_50M),
      .rst_n         (rst_n),
      .tick          (w_tick),
      .pressed       (w_pressed[i]),
      .level         (w_level[i]),
      .press_pulse   (w_press[i]),
      .release_pulse (w_rel[i]),
      .repeat_pulse  (w_rep[i])
    );
  end

  assign kif.key_level   = w_level;
  assign kif.key_press   = w_press;
  assign kif.key_release = w_rel;
  assign kif.key_repeat  = w_rep;
  assign kif.any_event   = |(w_press | w_rel | w_rep);

endmodule
`default_nettype wire

// File: tb/tb_key_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_key_scan
// Description : Directed self-checking bench for key_scan with a short tick
//               (TICK_DIV=4, DEBOUNCE_MS=3, LONG_MS=5, REPEAT_MS=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_scan;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int LONG     = 5;
  localparam int REP      = 2;
  // Raw edge to pulse: 2 sync + 1 FSM entry + DEB ticks, first tick partial.
  localparam int LAT_MIN  = (DEB - 1) * TICK_DIV + 3;
  localparam int LAT_MAX  = DEB * TICK_DIV + 3;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;

  always #10 clk_50M = ~clk_50M;

  key_scan_if kif ();

  key_scan #(
    .TICK_DIV       (TICK_DIV),
    .DEBOUNCE_MS    (DEB),
    .LONG_MS        (LONG),
    .REPEAT_MS      (REP),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .kif     (kif)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  int press_cnt [8];
  int rel_cnt   [8];
  int rep_cnt   [8];
  int press_cyc [8];
  int rel_cyc   [8];
  int rep_first [8];
  int rep2_q    [$];
  logic [7:0] prev_lvl = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Return to the drive phase: just after a rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  always @(posedge clk_50M) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge.
  always @(negedge clk_50M) begin
    check("any_event", kif.any_event, |(kif.key_press | kif.key_release | kif.key_repeat));
    for (int k = 0; k < 8; k++) begin
      if (kif.key_press[k]) begin
        press_cnt[k]++;
        press_cyc[k] = cyc;
        check($sformatf("press_level_k%0d", k), kif.key_level[k], 1);
        check($sformatf("press_prev_level_k%0d", k), prev_lvl[k], 0);
      end
      if (kif.key_release[k]) begin
        rel_cnt[k]++;
        rel_cyc[k] = cyc;
        check($sformatf("release_level_k%0d", k), kif.key_level[k], 0);
        check($sformatf("release_prev_level_k%0d", k), prev_lvl[k], 1);
      end
      if (kif.key_repeat[k]) begin
        if (rep_cnt[k] == 0) rep_first[k] = cyc;
        rep_cnt[k]++;
        if (k == 2) rep2_q.push_back(cyc);
      end
    end
    prev_lvl = kif.key_level;
  end

  initial begin
    int e1, e2, lat, snap_p, snap_r, snap_rep, r_edge, b1;
    for (int k = 0; k < 8; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; rep_cnt[k] = 0;
      press_cyc[k] = 0; rel_cyc[k] = 0; rep_first[k] = 0;
    end
    kif.key_in = 8'hFF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    check("rst_level",   kif.key_level,   0);
    check("rst_press",   kif.key_press,   0);
    check("rst_release", kif.key_release, 0);
    check("rst_repeat",  kif.key_repeat,  0);
    check("rst_any",     kif.any_event,   0);
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(5);

    // 1: clean press/release on key 4.
    kif.key_in[4] = 1'b0; e1 = cyc;
    wait_cyc(40);
    kif.key_in[4] = 1'b1; e2 = cyc;
    wait_cyc(20);
    check("t1_press_cnt", press_cnt[4], 1);
    check("t1_rel_cnt",   rel_cnt[4],   1);
    lat = press_cyc[4] - e1;
    check($sformatf("t1_press_lat_%0d_in_window", lat), (lat >= LAT_MIN && lat <= LAT_MAX), 1);
    lat = rel_cyc[4] - e2;
    check($sformatf("t1_rel_lat_%0d_in_window", lat), (lat >= LAT_MIN && lat <= LAT_MAX), 1);
    check("t1_level_end", kif.key_level[4], 0);

    // 2: short glitches on key 0 never qualify; then a sustained press does.
    for (int i = 0; i < 5; i++) begin
      kif.key_in[0] = 1'b0; wait_cyc(6);
      kif.key_in[0] = 1'b1; wait_cyc(2);
    end
    wait_cyc(10);
    check("t2_glitch_press", press_cnt[0], 0);
    check("t2_glitch_rel",   rel_cnt[0],   0);
    check("t2_glitch_level", kif.key_level[0], 0);
    kif.key_in[0] = 1'b0; wait_cyc(20);
    check("t2_sustained_press", press_cnt[0], 1);
    check("t2_level_held", kif.key_level[0], 1);
    kif.key_in[0] = 1'b1; wait_cyc(20);
    check("t2_rel", rel_cnt[0], 1);

    // 3: long hold of key 2, auto-repeat cadence.
    kif.key_in[2] = 1'b0; e1 = cyc;
    wait_cyc(100);
    kif.key_in[2] = 1'b1;
    wait_cyc(30);
    check("t3_press_cnt", press_cnt[2], 1);
    check("t3_rep_cnt", rep_cnt[2], 9);
    if (rep2_q.size() > 0) begin
      check("t3_first_rep_delay", rep2_q[0] - press_cyc[2], LONG * TICK_DIV);
      for (int i = 1; i < rep2_q.size(); i++)
        check($sformatf("t3_rep_gap_%0d", i), rep2_q[i] - rep2_q[i-1], REP * TICK_DIV);
      check("t3_no_rep_after_release", rep2_q[rep2_q.size()-1] < rel_cyc[2], 1);
    end
    check("t3_rel_cnt", rel_cnt[2], 1);

    // 4: keys 1 and 3 pressed together.
    kif.key_in[1] = 1'b0; kif.key_in[3] = 1'b0;
    wait_cyc(25);
    check("t4_press1_cnt", press_cnt[1], 1);
    check("t4_press3_cnt", press_cnt[3], 1);
    check("t4_same_cycle", press_cyc[1], press_cyc[3]);
    kif.key_in[1] = 1'b1; kif.key_in[3] = 1'b1;
    wait_cyc(20);
    check("t4_rel_same_cycle", rel_cyc[1], rel_cyc[3]);

    // 5: release bounce on key 5 while held restarts the long-press timer.
    kif.key_in[5] = 1'b0;
    wait_cyc(25);
    check("t5_press_cnt", press_cnt[5], 1);
    check("t5_no_early_rep", rep_cnt[5], 0);
    kif.key_in[5] = 1'b1; wait_cyc(3);
    kif.key_in[5] = 1'b0; b1 = cyc;
    wait_cyc(30);
    check("t5_no_release", rel_cnt[5], 0);
    check("t5_level_held", kif.key_level[5], 1);
    check("t5_rep_seen", rep_cnt[5] > 0, 1);
    lat = rep_first[5] - b1;
    check($sformatf("t5_first_rep_%0d_in_20_23", lat), (lat >= 20 && lat <= 23), 1);
    kif.key_in[5] = 1'b1; wait_cyc(20);
    check("t5_rel_cnt", rel_cnt[5], 1);

    // 6: reset while key 0 is auto-repeating and stays held.
    snap_p = press_cnt[0]; snap_r = rel_cnt[0]; snap_rep = rep_cnt[0];
    kif.key_in[0] = 1'b0;
    wait_cyc(40);
    check("t6_in_repeat", rep_cnt[0] > snap_rep, 1);
    check("t6_level_before", kif.key_level[0], 1);
    rst_n = 1'b0;
    @(posedge clk_50M);
    @(negedge clk_50M);
    check("t6_rst_level",   kif.key_level,   0);
    check("t6_rst_press",   kif.key_press,   0);
    check("t6_rst_release", kif.key_release, 0);
    check("t6_rst_repeat",  kif.key_repeat,  0);
    @(posedge clk_50M);
    #1;
    rst_n = 1'b1; r_edge = cyc;
    wait_cyc(20);
    check("t6_press_after_rst", press_cnt[0] - snap_p, 2);
    check("t6_press_cycle", press_cyc[0] - r_edge, 12);
    check("t6_no_release", rel_cnt[0] - snap_r, 0);
    kif.key_in[0] = 1'b1;
    wait_cyc(20);
    check("t6_final_release", rel_cnt[0] - snap_r, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_scan.md
# key_scan

Front-end keypad scanner for the 8-key panel. It synchronizes, debounces and classifies every raw key into single-cycle press, release and auto-repeat events, plus a clean level. Its outputs drive the menu controller's left/right/up/down/confirm/quit navigation and the parameter counters. One shared 1 ms tick paces all eight independent per-key state machines.

## Interface
- TICK_DIV, 50000: clk_50M cycles per tick (1 ms); legal range ≥ 2.
- DEBOUNCE_MS, 20: ticks a level must be stable to be accepted; legal range 1–1023.
- LONG_MS, 600: ticks of continuous hold before the first repeat; legal range 1–1023.
- REPEAT_MS, 150: ticks between subsequent repeats; legal range 1–1023.
- KEY_ACTIVE_LOW, 1: 1 means a raw 0 is pressed.
- clk_50M  in  1  system clock, 50 MHz
- rst_n  in  1  reset, synchronous, active-low
- key_in  in  8  raw asynchronous key pins
- key_level  out  8  debounced level, 1 = pressed
- key_press  out  8  one-cycle pulse on accepted press
- key_release  out  8  one-cycle pulse on accepted release
- key_repeat  out  8  one-cycle pulse on each auto-repeat while held
- any_event  out  1  OR of all press/release/repeat bits, same cycle

## Operation
- Sync: 2-flop synchronizer per key, then polarity normalised to pressed = 1. The synchronizer resets to the released level.
- Tick: divider counts 0..TICK_DIV-1. The tick strobe is high for one cycle when the divider reaches TICK_DIV-1.
- Each key has its own FSM and 10-bit counter cnt. Counters change only on tick, or clear on a state change.
- IDLE: if pressed, go to DB_PRESS with cnt = 0.
- DB_PRESS: if released, return to IDLE. On tick with cnt == DEBOUNCE_MS-1, go to HELD, pulse key_press, set key_level = 1, cnt = 0. On any other tick, cnt++.
- HELD: if released, go to DB_REL with cnt = 0. On tick with cnt == LONG_MS-1, go to REPEAT, pulse key_repeat, cnt = 0. On any other tick, cnt++.
- REPEAT: if released, go to DB_REL with cnt = 0. On tick with cnt == REPEAT_MS-1, pulse key_repeat, cnt = 0. On any other tick, cnt++.
- DB_REL: if pressed again (bounce), go to HELD with cnt = 0; the long-press timer restarts and no event is emitted. On tick with cnt == DEBOUNCE_MS-1, go to IDLE, pulse key_release, set key_level = 0.
- Release checks take priority over tick checks in every state.
- Keys are fully independent. Any combination of bits may pulse in the same cycle. A single key never pulses two event types in one cycle.
- Reset mid-operation:
  - All FSMs go to IDLE, all counters and the divider go to 0, all outputs go to 0.
  - No release pulse is emitted for a key that was held.
  - A key still held after reset yields a normal press after debounce.

## Timing
- Reset value of every output is 0.
- All outputs are registered. Pulses are high exactly one cycle: the cycle after the qualifying tick.
- Latency from a raw edge to the synchronized level is 2 cycles.
- Press latency is 2 cycles plus DEBOUNCE_MS ticks. The first tick is partial, so the value ranges over (DEBOUNCE_MS-1)·TICK_DIV to DEBOUNCE_MS·TICK_DIV cycles, plus about 3 cycles.
- First repeat comes LONG_MS ticks after the press. Subsequent repeats come every REPEAT_MS ticks.
- key_level changes in the same cycle as its press or release pulse.
- any_event is the combinational OR of the registered pulses, so it has no extra latency.

## Structure
- Package key_scan_pkg holds:
  - FSM state constants: IDLE, DB_PRESS, HELD, REPEAT, DB_REL (3-bit);
  - CNT_W = 10;
  - the default timing constants.
- Sub-module key_fsm holds one key's FSM, counter and output registers. It is instantiated 8× in a generate loop.
- The tick divider and synchronizers live in key_scan.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE_MS=3, LONG_MS=5, REPEAT_MS=2, KEY_ACTIVE_LOW=1.
1. Clean press of key_in[4] held 40 cycles, then released: exactly one key_press[4] and one key_release[4]. Each pulse comes 8–12 cycles after its edge (+2 sync). key_level[4] matches the pulse timing.
2. Glitches on key_in[0] shorter than 2 ticks (low 6 cycles, high 2 cycles, repeated): no events and key_level stays 0. A sustained low then yields one press.
3. Key 2 held 100 cycles: one press. The first repeat comes 20 cycles after the press, then a repeat every 8 cycles. No repeat follows the release.
4. Key 1 and key 3 pressed in the same cycle: key_press[1] and key_press[3] assert in the same cycle. any_event is high for that single cycle.
5. Release bounce on key 5 (high 3 cycles, then low) while in HELD: no release. The state returns to HELD and the first repeat is delayed by a full LONG_MS.
6. rst_n low for 2 cycles while key 0 is in REPEAT, with the key still held: all outputs go to 0 and no release is emitted. After reset, one key_press[0] comes after debounce.
